// File: rtl/bright_center_tracker.sv
// bright_center_tracker: per-frame centroid of bright pixels in the VGA stream.
// Each active frame accumulates the x of every bright pixel and the number of
// bright pixels. At frame end a serial restoring divider turns the sum into
// the mean x. The result is published for one cycle in UPDATE and is then held
// for the whole following frame. A centerX of 0 means "no target".
// Optional build macro CENTER_Y_EN adds a y accumulator, a second divide pass
// (DIVIDE_Y) and the center_y output port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ACCUM    | idle; waiting for the frame-end pixel
// DIVIDE_X | 28 restoring-division steps, sum_x / cnt, MSB first
// DIVIDE_Y | 28 restoring-division steps, sum_y / cnt (CENTER_Y_EN only)
// UPDATE   | publish results, pulse center_valid for one cycle
module bright_center_tracker #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter logic [7:0]  THRESH    = 8'hAF,
    parameter int unsigned MIN_COUNT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  vga_x,
    input  logic [9:0]  vga_y,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        video_active,
    output logic [9:0]  centerX,
    output logic        center_valid,
`ifdef CENTER_Y_EN
    output logic [9:0]  center_y,
`endif
    output logic [18:0] pixel_count
);

    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        DIVIDE_X = 2'd1,
`ifdef CENTER_Y_EN
        DIVIDE_Y = 2'd3,
`endif
        UPDATE   = 2'd2
    } state_t;

    state_t      state;

    logic        bright;
    logic        frame_end;
    logic [27:0] add_x;
    logic [27:0] sum_x;
    logic [18:0] cnt;
    logic [27:0] lat_sum_x_nx;
    logic [18:0] lat_cnt_nx;

    logic [18:0] lat_cnt;
    logic [27:0] dq;
    logic [18:0] rem;
    logic [4:0]  bit_cnt;
    logic [9:0]  res_x;

    logic [19:0] rem_sh;
    logic        div_ge;
    logic [18:0] rem_nx;
    logic [27:0] dq_nx;
    logic [9:0]  quot_fix;

`ifdef CENTER_Y_EN
    logic [27:0] add_y;
    logic [27:0] sum_y;
    logic [27:0] lat_sum_y_nx;
    logic [27:0] lat_sum_y;
    logic [9:0]  res_y;
`endif

    // Pixel classification and frame-end detection; the frame-end pixel's own
    // contribution is folded into the latched totals.
    always_comb begin
        bright    = video_active && (vga_r > THRESH) && (vga_g > THRESH) && (vga_b > THRESH);
        frame_end = video_active && (vga_x == 10'(H_ACTIVE - 1)) && (vga_y == 10'(V_ACTIVE - 1));
        add_x        = bright ? {18'd0, vga_x} : 28'd0;
        lat_sum_x_nx = sum_x + add_x;
        lat_cnt_nx   = cnt + {18'd0, bright};
`ifdef CENTER_Y_EN
        add_y        = bright ? {18'd0, vga_y} : 28'd0;
        lat_sum_y_nx = sum_y + add_y;
`endif
    end

    // One restoring-division step: shift in the next dividend bit, subtract the
    // divisor when it fits, and shift the quotient bit into dq's LSB.
    always_comb begin
        rem_sh   = {rem, dq[27]};
        div_ge   = (rem_sh >= {1'b0, lat_cnt});
        rem_nx   = div_ge ? 19'(rem_sh - {1'b0, lat_cnt}) : rem_sh[18:0];
        dq_nx    = {dq[26:0], div_ge};
        quot_fix = (dq_nx == 28'd0) ? 10'd1 : dq_nx[9:0];
    end

    // Frame accumulators; cleared on the edge after frame end, independent of the divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_x <= '0;
            cnt   <= '0;
`ifdef CENTER_Y_EN
            sum_y <= '0;
`endif
        end else if (frame_end) begin
            sum_x <= '0;
            cnt   <= '0;
`ifdef CENTER_Y_EN
            sum_y <= '0;
`endif
        end else if (bright) begin
            sum_x <= lat_sum_x_nx;
            cnt   <= lat_cnt_nx;
`ifdef CENTER_Y_EN
            sum_y <= lat_sum_y_nx;
`endif
        end
    end

    // Control FSM with divider datapath and registered outputs. A frame end in
    // any state relatches and restarts, dropping the unfinished frame's result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ACCUM;
            lat_cnt      <= '0;
            dq           <= '0;
            rem          <= '0;
            bit_cnt      <= '0;
            res_x        <= '0;
            centerX      <= '0;
            pixel_count  <= '0;
            center_valid <= 1'b0;
`ifdef CENTER_Y_EN
            lat_sum_y    <= '0;
            res_y        <= '0;
            center_y     <= '0;
`endif
        end else begin
            center_valid <= 1'b0;
            if (frame_end) begin
                lat_cnt <= lat_cnt_nx;
                dq      <= lat_sum_x_nx;
                rem     <= '0;
                bit_cnt <= '0;
`ifdef CENTER_Y_EN
                lat_sum_y <= lat_sum_y_nx;
`endif
                if (lat_cnt_nx < 19'(MIN_COUNT)) begin
                    res_x <= '0;
`ifdef CENTER_Y_EN
                    res_y <= '0;
`endif
                    state <= UPDATE;
                end else begin
                    state <= DIVIDE_X;
                end
            end else begin
                case (state)
                    ACCUM: ;
                    DIVIDE_X: begin
                        rem     <= rem_nx;
                        dq      <= dq_nx;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd27) begin
                            res_x <= quot_fix;
`ifdef CENTER_Y_EN
                            dq      <= lat_sum_y;
                            rem     <= '0;
                            bit_cnt <= '0;
                            state   <= DIVIDE_Y;
`else
                            state   <= UPDATE;
`endif
                        end
                    end
`ifdef CENTER_Y_EN
                    DIVIDE_Y: begin
                        rem     <= rem_nx;
                        dq      <= dq_nx;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd27) begin
                            res_y <= quot_fix;
                            state <= UPDATE;
                        end
                    end
`endif
                    UPDATE: begin
                        centerX      <= res_x;
                        pixel_count  <= lat_cnt;
                        center_valid <= 1'b1;
`ifdef CENTER_Y_EN
                        center_y     <= res_y;
`endif
                        state        <= ACCUM;
                    end
                    default: state <= ACCUM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bright_center_tracker.sv
// Directed testbench for bright_center_tracker. Frames are driven sparsely:
// only bright pixels and the frame-end pixel are presented, since black pixels
// contribute nothing to the sums.
module tb_bright_center_tracker;

`ifdef CENTER_Y_EN
    localparam int LAT = 58;
`else
    localparam int LAT = 30;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  vga_x = '0;
    logic [9:0]  vga_y = '0;
    logic [7:0]  vga_r = '0;
    logic [7:0]  vga_g = '0;
    logic [7:0]  vga_b = '0;
    logic        video_active = 1'b0;
    logic [9:0]  centerX;
    logic        center_valid;
    logic [18:0] pixel_count;
`ifdef CENTER_Y_EN
    logic [9:0]  center_y;
`endif

    int checks = 0;
    int fails  = 0;
    int pulse_total = 0;

    bright_center_tracker dut (
        .clk(clk),
        .rst(rst),
        .vga_x(vga_x),
        .vga_y(vga_y),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .video_active(video_active),
        .centerX(centerX),
        .center_valid(center_valid),
`ifdef CENTER_Y_EN
        .center_y(center_y),
`endif
        .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (center_valid === 1'b1) pulse_total++;

    task automatic idle();
        video_active = 1'b0;
        vga_r = 8'd0; vga_g = 8'd0; vga_b = 8'd0;
        vga_x = 10'd0; vga_y = 10'd0;
    endtask

    // Present one pixel for one clock; returns 1 ns after the sampling edge.
    task automatic pix(input int x, input int y, input bit white, input bit act);
        vga_x = 10'(x);
        vga_y = 10'(y);
        vga_r = white ? 8'hFF : 8'h00;
        vga_g = white ? 8'hFF : 8'h00;
        vga_b = white ? 8'hFF : 8'h00;
        video_active = act;
        @(posedge clk); #1;
    endtask

    task automatic frame_end_pix(input bit white);
        pix(639, 479, white, 1'b1);
        idle();
    endtask

    // Watches center_valid for a bounded number of edges after the frame-end edge.
    task automatic wait_pulse(input int budget, output int first, output int pulses);
        first = -1;
        pulses = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (center_valid === 1'b1) begin
                if (pulses == 0) first = i;
                pulses++;
            end
        end
    endtask

    task automatic draw_square();
        for (int y = 100; y < 110; y++)
            for (int x = 300; x < 310; x++)
                pix(x, y, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (centerX !== 10'd0) begin fails++; $display("FAIL reset_cx got %0d want 0", centerX); end
        checks++; if (pixel_count !== 19'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", pixel_count); end
        checks++; if (center_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", center_valid); end
`ifdef CENTER_Y_EN
        checks++; if (center_y !== 10'd0) begin fails++; $display("FAIL reset_cy got %0d want 0", center_y); end
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_square();
        int first, pulses;
        draw_square();
        frame_end_pix(1'b0);
        wait_pulse(LAT + 5, first, pulses);
        checks++; if (first != LAT - 1) begin fails++; $display("FAIL square_latency got %0d want %0d", first + 1, LAT); end
        checks++; if (pulses != 1) begin fails++; $display("FAIL square_pulses got %0d want 1", pulses); end
        checks++; if (centerX !== 10'd304) begin fails++; $display("FAIL square_cx got %0d want 304", centerX); end
        checks++; if (pixel_count !== 19'd100) begin fails++; $display("FAIL square_cnt got %0d want 100", pixel_count); end
`ifdef CENTER_Y_EN
        checks++; if (center_y !== 10'd104) begin fails++; $display("FAIL square_cy got %0d want 104", center_y); end
`endif
    endtask

    task automatic test_few_pixels();
        int first, pulses;
        for (int x = 200; x < 250; x++) pix(x, 50, 1'b1, 1'b1);
        frame_end_pix(1'b0);
        wait_pulse(LAT + 5, first, pulses);
        checks++; if (first != 1) begin fails++; $display("FAIL few_latency got %0d want 2", first + 1); end
        checks++; if (pulses != 1) begin fails++; $display("FAIL few_pulses got %0d want 1", pulses); end
        checks++; if (centerX !== 10'd0) begin fails++; $display("FAIL few_cx got %0d want 0", centerX); end
        checks++; if (pixel_count !== 19'd50) begin fails++; $display("FAIL few_cnt got %0d want 50", pixel_count); end
`ifdef CENTER_Y_EN
        checks++; if (center_y !== 10'd0) begin fails++; $display("FAIL few_cy got %0d want 0", center_y); end
`endif
    endtask

    task automatic test_column_zero();
        int first, pulses;
        for (int y = 0; y < 480; y++) pix(0, y, 1'b1, 1'b1);
        frame_end_pix(1'b0);
        wait_pulse(LAT + 5, first, pulses);
        checks++; if (first != LAT - 1) begin fails++; $display("FAIL column_latency got %0d want %0d", first + 1, LAT); end
        checks++; if (centerX !== 10'd1) begin fails++; $display("FAIL column_cx got %0d want 1", centerX); end
        checks++; if (pixel_count !== 19'd480) begin fails++; $display("FAIL column_cnt got %0d want 480", pixel_count); end
`ifdef CENTER_Y_EN
        checks++; if (center_y !== 10'd239) begin fails++; $display("FAIL column_cy got %0d want 239", center_y); end
`endif
    endtask

    task automatic test_last_pixel();
        int first, pulses;
        for (int i = 0; i < 99; i++) pix(100, 10, 1'b1, 1'b1);
        pix(700, 10, 1'b1, 1'b0);
        pix(639, 479, 1'b1, 1'b0);
        frame_end_pix(1'b1);
        wait_pulse(LAT + 5, first, pulses);
        checks++; if (first != LAT - 1) begin fails++; $display("FAIL last_latency got %0d want %0d", first + 1, LAT); end
        checks++; if (pixel_count !== 19'd100) begin fails++; $display("FAIL last_cnt got %0d want 100", pixel_count); end
        checks++; if (centerX !== 10'd105) begin fails++; $display("FAIL last_cx got %0d want 105", centerX); end
`ifdef CENTER_Y_EN
        checks++; if (center_y !== 10'd14) begin fails++; $display("FAIL last_cy got %0d want 14", center_y); end
`endif
    endtask

    task automatic test_reset_mid_divide();
        int first, pulses, p0;
        draw_square();
        frame_end_pix(1'b0);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (centerX !== 10'd0) begin fails++; $display("FAIL rstmid_cx got %0d want 0", centerX); end
        checks++; if (pixel_count !== 19'd0) begin fails++; $display("FAIL rstmid_cnt got %0d want 0", pixel_count); end
        checks++; if (center_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %0b want 0", center_valid); end
`ifdef CENTER_Y_EN
        checks++; if (center_y !== 10'd0) begin fails++; $display("FAIL rstmid_cy got %0d want 0", center_y); end
`endif
        #2 rst = 1'b1;
        p0 = pulse_total;
        repeat (LAT + 5) @(posedge clk);
        #1;
        checks++; if (pulse_total != p0) begin fails++; $display("FAIL rstmid_stale_pulse got %0d want 0", pulse_total - p0); end
        draw_square();
        frame_end_pix(1'b0);
        wait_pulse(LAT + 5, first, pulses);
        checks++; if (first != LAT - 1) begin fails++; $display("FAIL rstmid_latency got %0d want %0d", first + 1, LAT); end
        checks++; if (centerX !== 10'd304) begin fails++; $display("FAIL rstmid_cx2 got %0d want 304", centerX); end
        checks++; if (pixel_count !== 19'd100) begin fails++; $display("FAIL rstmid_cnt2 got %0d want 100", pixel_count); end
    endtask

    task automatic test_back_to_back();
        int first, pulses, p0;
        p0 = pulse_total;
        draw_square();
        frame_end_pix(1'b0);
        for (int i = 0; i < 10; i++) pix(20, i, 1'b1, 1'b1);
        checks++; if (centerX !== 10'd304) begin fails++; $display("FAIL b2b_hold_cx got %0d want 304", centerX); end
        frame_end_pix(1'b0);
        wait_pulse(LAT + 5, first, pulses);
        checks++; if (first != 1) begin fails++; $display("FAIL b2b_latency got %0d want 2", first + 1); end
        checks++; if (pulse_total - p0 != 1) begin fails++; $display("FAIL b2b_pulses got %0d want 1", pulse_total - p0); end
        checks++; if (centerX !== 10'd0) begin fails++; $display("FAIL b2b_cx got %0d want 0", centerX); end
        checks++; if (pixel_count !== 19'd10) begin fails++; $display("FAIL b2b_cnt got %0d want 10", pixel_count); end
    endtask

    initial begin
        idle();
        test_reset();
        test_square();
        test_few_pixels();
        test_column_zero();
        test_last_pixel();
        test_reset_mid_divide();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
